// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - request/response and dALU signal bundle for alu_dispatch
// slave is the dispatcher side; master is the CPU stage plus dALU side.
interface alu_dispatch_if #(
  parameter int TAG_W = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_op;
  logic [15:0]      req_a;
  logic [15:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic [7:0]       alu_op;
  logic             alu_cf;
  logic [15:0]      alu_acc;
  logic [15:0]      alu_c;
  logic             alu_c_flag;
  logic             alu_z_flag;
  logic             alu_o_flag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [15:0]      rsp_acc;
  logic [15:0]      rsp_hi;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             flag_c;
  logic             flag_z;
  logic             flag_o;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
           alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag,
    output req_ready, alu_a, alu_b, alu_op, alu_cf,
           rsp_valid, rsp_acc, rsp_hi, rsp_tag, rsp_err, flag_c, flag_z, flag_o
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
           alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag,
    input  req_ready, alu_a, alu_b, alu_op, alu_cf,
           rsp_valid, rsp_acc, rsp_hi, rsp_tag, rsp_err, flag_c, flag_z, flag_o
  );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - one-at-a-time dALU dispatcher holding the C/Z/O flags register
// Define ALU_DISPATCH_DIVZERO_EN to trap divides by zero before they reach the ALU.
module alu_dispatch #(
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_dispatch_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int         CNT_W  = $clog2(ALU_LAT + 1) + 1;
  localparam logic [7:0] OP_ADD = 8'd1, OP_ADC = 8'd2, OP_SUB = 8'd3, OP_SUC = 8'd4;
  localparam logic [7:0] OP_MUL8 = 8'd5, OP_MUL6 = 8'd6, OP_DIV8 = 8'd7, OP_DIV6 = 8'd8;
  localparam logic [7:0] OP_CMP = 8'd9;

  state_t           r_state;
  logic [7:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic [7:0]       r_alu_op;
  logic [15:0]      r_alu_a, r_alu_b;
  logic             r_alu_cf;
  logic             r_rsp_valid;
  logic [15:0]      r_rsp_acc, r_rsp_hi;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_err;
  logic             r_flag_c, r_flag_z, r_flag_o;
  logic             w_legal;
  logic             w_divzero;

  assign w_legal = (bus.req_op >= OP_ADD) && (bus.req_op <= OP_CMP);

`ifdef ALU_DISPATCH_DIVZERO_EN
  assign w_divzero = ((bus.req_op == OP_DIV8) && (bus.req_b[7:0] == 8'd0)) ||
                     ((bus.req_op == OP_DIV6) && (bus.req_b == 16'd0));
`else
  assign w_divzero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 8'd0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_alu_op    <= 8'd0;
      r_alu_a     <= 16'd0;
      r_alu_b     <= 16'd0;
      r_alu_cf    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_acc   <= 16'd0;
      r_rsp_hi    <= 16'd0;
      r_rsp_tag   <= '0;
      r_rsp_err   <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_o    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_op        <= bus.req_op;
            r_rsp_tag   <= bus.req_tag;
            if (!w_legal || w_divzero) begin
              // Rejected ops answer immediately and never touch the ALU or the flags.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_acc   <= w_legal ? 16'hFFFF : 16'd0;
              r_rsp_hi    <= w_legal ? 16'hFFFF : 16'd0;
              r_state     <= S_RESP;
            end else begin
              r_alu_op <= bus.req_op;
              r_alu_a  <= bus.req_a;
              r_alu_b  <= bus.req_b;
              r_alu_cf <= r_flag_c;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_alu_op <= 8'd0;
          r_cnt    <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(ALU_LAT)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_acc   <= bus.alu_acc;
            r_rsp_hi    <= ((r_op == OP_MUL6) || (r_op == OP_DIV6)) ? bus.alu_c : 16'd0;
            case (r_op)
              OP_ADD, OP_ADC, OP_SUB, OP_SUC, OP_CMP: begin
                r_flag_c <= bus.alu_c_flag;
                r_flag_z <= bus.alu_z_flag;
                r_flag_o <= bus.alu_o_flag;
              end
              OP_MUL8, OP_MUL6, OP_DIV8, OP_DIV6: r_flag_z <= bus.alu_z_flag;
              default: ;
            endcase
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_cf    = r_alu_cf;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_acc   = r_rsp_acc;
  assign bus.rsp_hi    = r_rsp_hi;
  assign bus.rsp_tag   = r_rsp_tag;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_o    = r_flag_o;
endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed self-checking bench for alu_dispatch with a small dALU model
module tb_alu_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   issue_cnt = 0;
    logic last_cf = 1'b0;
    int   lat;
    int   n0;
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] hold_acc;

    alu_dispatch_if #(.TAG_W(3)) bus ();
    alu_dispatch #(.ALU_LAT(1), .TAG_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_acc <= 16'd0; bus.alu_c <= 16'd0;
            bus.alu_c_flag <= 1'b0; bus.alu_z_flag <= 1'b0; bus.alu_o_flag <= 1'b0;
        end else if (bus.alu_op != 8'd0) begin
            case (bus.alu_op)
                8'd1, 8'd2: begin
                    s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + ((bus.alu_op == 8'd2) ? {16'd0, bus.alu_cf} : 17'd0);
                    bus.alu_acc <= s[15:0]; bus.alu_c_flag <= s[16]; bus.alu_z_flag <= (s[15:0] == 16'd0);
                    bus.alu_o_flag <= (bus.alu_a[15] == bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
                end
                8'd3, 8'd4: begin
                    s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - ((bus.alu_op == 8'd4) ? {16'd0, bus.alu_cf} : 17'd0);
                    bus.alu_acc <= s[15:0]; bus.alu_c_flag <= s[16]; bus.alu_z_flag <= (s[15:0] == 16'd0);
                    bus.alu_o_flag <= (bus.alu_a[15] != bus.alu_b[15]) && (s[15] != bus.alu_a[15]);
                end
                8'd5, 8'd6: begin
                    p = (bus.alu_op == 8'd5) ? {16'd0, 8'd0, bus.alu_a[7:0]} * {16'd0, 8'd0, bus.alu_b[7:0]}
                                             : {16'd0, bus.alu_a} * {16'd0, bus.alu_b};
                    bus.alu_acc <= p[15:0]; bus.alu_c <= p[31:16]; bus.alu_z_flag <= (p == 32'd0);
                    bus.alu_c_flag <= 1'b1; bus.alu_o_flag <= 1'b0;
                end
                8'd7, 8'd8: begin
                    bus.alu_acc <= (bus.alu_b == 16'd0) ? 16'hFFFF : bus.alu_a / bus.alu_b;
                    bus.alu_c   <= (bus.alu_b == 16'd0) ? 16'hFFFF : bus.alu_a % bus.alu_b;
                    bus.alu_z_flag <= (bus.alu_b != 16'd0) && (bus.alu_a < bus.alu_b);
                    bus.alu_c_flag <= 1'b1; bus.alu_o_flag <= 1'b0;
                end
                8'd9: begin
                    bus.alu_c_flag <= bus.alu_a < bus.alu_b; bus.alu_z_flag <= bus.alu_a == bus.alu_b;
                    bus.alu_o_flag <= bus.alu_a > bus.alu_b;
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.alu_op != 8'd0) begin
            issue_cnt <= issue_cnt + 1;
            last_cf   <= bus.alu_cf;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] tag, output int l);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        l = 0;
        while (!bus.rsp_valid && l < 20) begin @(posedge clk); #1; l++; end
    endtask

    task automatic do_ack();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $error("FAIL ack_rsp_valid obs=%0h", bus.rsp_valid); end
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $error("FAIL ack_req_ready obs=%0h", bus.req_ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 8'd0; bus.req_a = 16'd0; bus.req_b = 16'd0;
        bus.req_tag = 3'd0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cf} !==
            {1'b1, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0}) begin bad++; $error("FAIL reset_outputs"); end
        total++;
        if ({bus.rsp_acc, bus.rsp_hi, bus.rsp_tag, bus.rsp_err, bus.flag_c, bus.flag_z, bus.flag_o} !==
            {16'd0, 16'd0, 3'd0, 1'b0, 3'b000}) begin bad++; $error("FAIL reset_rsp"); end
        rst_n = 1'b1;

        do_req(8'd1, 16'h7FFF, 16'h0001, 3'd1, lat);
        total++;
        if (lat !== 3) begin bad++; $error("FAIL add_lat obs=%0d", lat); end
        total++;
        if (bus.rsp_acc !== 16'h8000) begin bad++; $error("FAIL add_acc obs=%0h", bus.rsp_acc); end
        total++;
        if ({bus.rsp_hi, bus.rsp_tag, bus.rsp_err} !== {16'h0000, 3'd1, 1'b0}) begin bad++; $error("FAIL add_hi_tag_err"); end
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b001) begin bad++; $error("FAIL add_flags"); end
        do_ack();

        do_req(8'd6, 16'h1234, 16'h0100, 3'd2, lat);
        total++;
        if (lat !== 3) begin bad++; $error("FAIL mul6_lat obs=%0d", lat); end
        total++;
        if ({bus.rsp_hi, bus.rsp_acc, bus.rsp_tag} !== {16'h0012, 16'h3400, 3'd2}) begin bad++; $error("FAIL mul6_res"); end
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b001) begin bad++; $error("FAIL mul6_flags"); end
        do_ack();

        do_req(8'd3, 16'h0000, 16'h0001, 3'd3, lat);
        total++;
        if (last_cf !== 1'b0) begin bad++; $error("FAIL sub_cf_issue"); end
        total++;
        if (bus.rsp_acc !== 16'hFFFF) begin bad++; $error("FAIL sub_acc obs=%0h", bus.rsp_acc); end
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b100) begin bad++; $error("FAIL sub_flags"); end
        do_ack();

        do_req(8'd4, 16'h0005, 16'h0002, 3'd4, lat);
        total++;
        if (last_cf !== 1'b1) begin bad++; $error("FAIL suc_cf_issue"); end
        total++;
        if (bus.rsp_acc !== 16'h0002) begin bad++; $error("FAIL suc_acc obs=%0h", bus.rsp_acc); end
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b000) begin bad++; $error("FAIL suc_flags"); end
        do_ack();

        do_req(8'd9, 16'h0003, 16'h0005, 3'd5, lat);
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b100) begin bad++; $error("FAIL cmp_lt_flags"); end
        total++;
        if ({bus.rsp_acc, bus.rsp_hi} !== {16'h0002, 16'h0000}) begin bad++; $error("FAIL cmp_lt_acc_hi"); end
        do_ack();

        do_req(8'd9, 16'h0005, 16'h0005, 3'd6, lat);
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b010) begin bad++; $error("FAIL cmp_eq_flags"); end
        total++;
        if (bus.rsp_acc !== 16'h0002) begin bad++; $error("FAIL cmp_eq_acc obs=%0h", bus.rsp_acc); end
        hold_acc = bus.rsp_acc;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.rsp_valid, bus.rsp_acc, bus.rsp_tag, bus.rsp_err} !== {1'b1, hold_acc, 3'd6, 1'b0}) begin
                bad++; $error("FAIL bp_rsp_stable");
            end
            total++;
            if ({bus.req_ready, bus.alu_op} !== {1'b0, 8'd0}) begin bad++; $error("FAIL bp_idle_ports"); end
        end
        do_ack();

        n0 = issue_cnt;
        do_req(8'h0A, 16'h1111, 16'h2222, 3'd7, lat);
        total++;
        if (lat !== 0) begin bad++; $error("FAIL ill_lat obs=%0d", lat); end
        total++;
        if ({bus.rsp_err, bus.rsp_acc, bus.rsp_hi, bus.rsp_tag} !== {1'b1, 16'd0, 16'd0, 3'd7}) begin bad++; $error("FAIL ill_rsp"); end
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b010) begin bad++; $error("FAIL ill_flags"); end
        do_ack();
        total++;
        if (issue_cnt !== n0) begin bad++; $error("FAIL ill_no_issue"); end

`ifdef ALU_DISPATCH_DIVZERO_EN
        n0 = issue_cnt;
        do_req(8'd8, 16'h0010, 16'h0000, 3'd5, lat);
        total++;
        if (lat !== 0) begin bad++; $error("FAIL dz_lat obs=%0d", lat); end
        total++;
        if ({bus.rsp_err, bus.rsp_acc, bus.rsp_hi, bus.rsp_tag} !== {1'b1, 16'hFFFF, 16'hFFFF, 3'd5}) begin bad++; $error("FAIL dz_rsp"); end
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b010) begin bad++; $error("FAIL dz_flags"); end
        do_ack();
        total++;
        if (issue_cnt !== n0) begin bad++; $error("FAIL dz_no_issue"); end
`else
        do_req(8'd8, 16'h0007, 16'h0002, 3'd5, lat);
        total++;
        if (lat !== 3) begin bad++; $error("FAIL div6_lat obs=%0d", lat); end
        total++;
        if ({bus.rsp_err, bus.rsp_acc, bus.rsp_hi} !== {1'b0, 16'h0003, 16'h0001}) begin bad++; $error("FAIL div6_rsp"); end
        total++;
        if ({bus.flag_c, bus.flag_z, bus.flag_o} !== 3'b000) begin bad++; $error("FAIL div6_flags"); end
        do_ack();
`endif

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 8'd1; bus.req_a = 16'h0001; bus.req_b = 16'h0001; bus.req_tag = 3'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.req_ready, bus.rsp_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cf} !==
            {1'b1, 1'b0, 8'd0, 16'd0, 16'd0, 1'b0}) begin bad++; $error("FAIL rst_mid_ctl"); end
        total++;
        if ({bus.rsp_acc, bus.rsp_tag, bus.flag_c, bus.flag_z, bus.flag_o} !== {16'd0, 3'd0, 3'b000}) begin
            bad++; $error("FAIL rst_mid_rsp");
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $error("FAIL rst_no_rsp"); end
        do_req(8'd1, 16'h0001, 16'h0002, 3'd2, lat);
        total++;
        if (lat !== 3) begin bad++; $error("FAIL post_rst_lat obs=%0d", lat); end
        total++;
        if ({bus.rsp_acc, bus.rsp_tag, bus.flag_c, bus.flag_z, bus.flag_o} !== {16'h0003, 3'd2, 3'b000}) begin
            bad++; $error("FAIL post_rst_rsp");
        end
        do_ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
